// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : btb_predictor
//  Purpose  : Direct-mapped branch target buffer with a 2-bit saturating
//             direction counter per entry. The IF stage looks up the fetch PC
//             combinationally. The EX stage trains the table with the resolved
//             PC, outcome and target. Two saturating performance counters track
//             resolved control-flow instructions and mispredictions.
//
//  Ports    : clk                 - rising-edge clock
//             rst_n               - synchronous active-low reset
//             pc_if               - fetch PC being looked up
//             predictedTaken_if   - hit AND counter MSB
//             predicted_target_if - stored target on hit, else 0
//             btb_hit_if          - valid entry with matching tag
//             update_btb_ex       - a control-flow instruction resolved in EX
//             pc_ex               - PC of the resolved instruction
//             ex_branch_taken     - actual outcome
//             jump_addr_ex        - computed target
//             modify_pc_ex        - EX mispredict/redirect flag
//             ctrl_count          - resolved control-flow count (saturating)
//             mispredict_count    - misprediction count (saturating)
//
//  Revision : 1.0 - initial release
// ============================================================================
module btb_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] pc_if,
    output logic        predictedTaken_if,
    output logic [31:0] predicted_target_if,
    output logic        btb_hit_if,

    input  logic        update_btb_ex,
    input  logic [31:0] pc_ex,
    input  logic        ex_branch_taken,
    input  logic [31:0] jump_addr_ex,
    input  logic        modify_pc_ex,

    output logic [31:0] ctrl_count,
    output logic [31:0] mispredict_count
);

    localparam int         c_ENTRIES = 1 << INDEX_BITS;
    localparam int         c_TAG_W   = 30 - INDEX_BITS;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WNT = 2'b01;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic                 r_valid  [c_ENTRIES];
    logic [c_TAG_W-1:0]   r_tag    [c_ENTRIES];
    logic [31:0]          r_target [c_ENTRIES];
    logic [1:0]           r_ctr    [c_ENTRIES];

    logic [31:0]          r_ctrl_count;
    logic [31:0]          r_misp_count;

    // ------------------------------------------------------------------
    // Index / tag extraction. pc[1:0] never participates.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_if_idx;
    logic [c_TAG_W-1:0]    w_if_tag;
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [c_TAG_W-1:0]    w_ex_tag;
    logic                  w_unused_pc_lsbs;

    assign w_if_idx = pc_if[INDEX_BITS+1:2];
    assign w_if_tag = pc_if[31:INDEX_BITS+2];
    assign w_ex_idx = pc_ex[INDEX_BITS+1:2];
    assign w_ex_tag = pc_ex[31:INDEX_BITS+2];

    assign w_unused_pc_lsbs = &{1'b0, pc_if[1:0], pc_ex[1:0]};

    // ------------------------------------------------------------------
    // Lookup: purely combinational from the registered table, so a
    // same-cycle update to the same index is not visible until the next
    // cycle (read-before-write, no bypass).
    // ------------------------------------------------------------------
    logic w_if_hit;

    assign w_if_hit            = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign btb_hit_if          = w_if_hit;
    assign predictedTaken_if   = w_if_hit && r_ctr[w_if_idx][1];
    assign predicted_target_if = w_if_hit ? r_target[w_if_idx] : 32'h0;

    // ------------------------------------------------------------------
    // Update decision
    // ------------------------------------------------------------------
    logic       w_ex_hit;
    logic       w_train;   // hit: adjust counter (and target if taken)
    logic       w_alloc;   // miss + taken: claim the slot, evicting any alias
    logic [1:0] w_ctr_cur;
    logic [1:0] w_ctr_next;

    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_train   = update_btb_ex && w_ex_hit;
    assign w_alloc   = update_btb_ex && !w_ex_hit && ex_branch_taken;
    assign w_ctr_cur = r_ctr[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (ex_branch_taken) begin
            if (w_ctr_cur != c_CTR_ST) begin
                w_ctr_next = w_ctr_cur + 2'd1;
            end
        end else begin
            if (w_ctr_cur != c_CTR_SNT) begin
                w_ctr_next = w_ctr_cur - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_WNT;
            end
        end else if (w_alloc) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= jump_addr_ex;
            r_ctr[w_ex_idx]    <= c_CTR_WT;
        end else if (w_train) begin
            r_ctr[w_ex_idx] <= w_ctr_next;
            // A taken hit refreshes the target so a moved JALR destination
            // replaces the stale one; a not-taken hit keeps it.
            if (ex_branch_taken) begin
                r_target[w_ex_idx] <= jump_addr_ex;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_count <= '0;
            r_misp_count <= '0;
        end else begin
            if (update_btb_ex && (r_ctrl_count != c_CNT_MAX)) begin
                r_ctrl_count <= r_ctrl_count + 32'd1;
            end
            if (modify_pc_ex && (r_misp_count != c_CNT_MAX)) begin
                r_misp_count <= r_misp_count + 32'd1;
            end
        end
    end

    assign ctrl_count       = r_ctrl_count;
    assign mispredict_count = r_misp_count;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_predictor
//  Purpose  : Directed bench for btb_predictor. Each stimulus cycle pushes its
//             hand-computed expected lookup/counter values into a queue; a
//             monitor pops and compares them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btb_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        predictedTaken_if;
    logic [31:0] predicted_target_if;
    logic        btb_hit_if;
    logic        update_btb_ex;
    logic [31:0] pc_ex;
    logic        ex_branch_taken;
    logic [31:0] jump_addr_ex;
    logic        modify_pc_ex;
    logic [31:0] ctrl_count;
    logic [31:0] mispredict_count;

    btb_predictor #(.INDEX_BITS(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_if               (pc_if),
        .predictedTaken_if   (predictedTaken_if),
        .predicted_target_if (predicted_target_if),
        .btb_hit_if          (btb_hit_if),
        .update_btb_ex       (update_btb_ex),
        .pc_ex               (pc_ex),
        .ex_branch_taken     (ex_branch_taken),
        .jump_addr_ex        (jump_addr_ex),
        .modify_pc_ex        (modify_pc_ex),
        .ctrl_count          (ctrl_count),
        .mispredict_count    (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] ctrl;
        logic [31:0] misp;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares the outputs of the cycle whose stimulus was pushed.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            checks++;
            if (btb_hit_if !== e.hit) begin
                errors++;
                $display("FAIL %s hit: got %0b expected %0b", e.nm, btb_hit_if, e.hit);
            end
            checks++;
            if (predictedTaken_if !== e.tk) begin
                errors++;
                $display("FAIL %s taken: got %0b expected %0b", e.nm, predictedTaken_if, e.tk);
            end
            checks++;
            if (predicted_target_if !== e.tgt) begin
                errors++;
                $display("FAIL %s target: got %h expected %h", e.nm, predicted_target_if, e.tgt);
            end
            checks++;
            if (ctrl_count !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl_count: got %h expected %h", e.nm, ctrl_count, e.ctrl);
            end
            checks++;
            if (mispredict_count !== e.misp) begin
                errors++;
                $display("FAIL %s mispredict_count: got %h expected %h", e.nm, mispredict_count, e.misp);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge and record the
    // outputs expected during this cycle (pre-update table contents).
    task automatic step(input string nm, input logic rn, input logic [31:0] pci,
                        input logic upd, input logic [31:0] pce, input logic tk,
                        input logic [31:0] ja, input logic mod,
                        input logic eh, input logic et, input logic [31:0] etg,
                        input logic [31:0] ec, input logic [31:0] em);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rn;
        pc_if           = pci;
        update_btb_ex   = upd;
        pc_ex           = pce;
        ex_branch_taken = tk;
        jump_addr_ex    = ja;
        modify_pc_ex    = mod;
        e.nm = nm; e.hit = eh; e.tk = et; e.tgt = etg; e.ctrl = ec; e.misp = em;
        q_exp.push_back(e);
    endtask

    localparam logic [31:0] MX  = 32'hFFFF_FFFF;
    localparam logic [31:0] MX1 = 32'hFFFF_FFFE;

    initial begin
        rst_n = 1'b0; pc_if = '0; update_btb_ex = 1'b0; pc_ex = '0;
        ex_branch_taken = 1'b0; jump_addr_ex = '0; modify_pc_ex = 1'b0;
        repeat (2) @(posedge clk);

        //     name            rn  pc_if  upd pc_ex  tk ja      mod  hit tk tgt     ctrl misp
        step("reset_lookup",   1, 32'h40, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,   0, 0);
        step("alloc_issue",    1, 32'h40, 1, 32'h40, 1, 32'h100, 0,   0, 0, 32'h0,   0, 0);
        step("alloc_lookup",   1, 32'h40, 1, 32'h40, 1, 32'h100, 0,   1, 1, 32'h100, 1, 0);
        step("ctr_inc",        1, 32'h40, 1, 32'h40, 1, 32'h100, 0,   1, 1, 32'h100, 2, 0);
        step("ctr_st",         1, 32'h40, 1, 32'h40, 0, 32'h0,   0,   1, 1, 32'h100, 3, 0);
        step("ctr_wt",         1, 32'h40, 1, 32'h40, 0, 32'h0,   0,   1, 1, 32'h100, 4, 0);
        step("ctr_wnt",        1, 32'h40, 1, 32'h40, 0, 32'h0,   0,   1, 0, 32'h100, 5, 0);
        step("ctr_snt",        1, 32'h40, 1, 32'h40, 0, 32'h0,   0,   1, 0, 32'h100, 6, 0);
        step("ctr_snt_hold",   1, 32'h40, 1, 32'h40, 1, 32'h100, 0,   1, 0, 32'h100, 7, 0);
        step("ctr_back_wnt",   1, 32'h40, 0, 32'h00, 0, 32'h0,   0,   1, 0, 32'h100, 8, 0);
        step("jalr_retarget",  1, 32'h40, 1, 32'h40, 1, 32'h104, 0,   1, 0, 32'h100, 8, 0);
        step("jalr_new_tgt",   1, 32'h40, 0, 32'h00, 0, 32'h0,   0,   1, 1, 32'h104, 9, 0);
        step("alias_issue",    1, 32'h80, 1, 32'h80, 1, 32'h200, 0,   0, 0, 32'h0,   9, 0);
        step("alias_evict",    1, 32'h40, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,  10, 0);
        step("alias_hit",      1, 32'h80, 1, 32'hC0, 0, 32'h0,   0,   1, 1, 32'h200,10, 0);
        step("nt_no_alloc",    1, 32'hC0, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,  11, 0);
        step("rbw_same",       1, 32'h80, 1, 32'h80, 0, 32'h0,   0,   1, 1, 32'h200,11, 0);
        step("rbw_next",       1, 32'h80, 0, 32'h00, 0, 32'h0,   0,   1, 0, 32'h200,12, 0);
        step("idx1_issue",     1, 32'h44, 1, 32'h44, 1, 32'h300, 0,   0, 0, 32'h0,  12, 0);
        step("idx1_lookup",    1, 32'h44, 0, 32'h00, 0, 32'h0,   1,   1, 1, 32'h300,13, 0);
        step("misp_1",         1, 32'h44, 0, 32'h00, 0, 32'h0,   1,   1, 1, 32'h300,13, 1);
        step("misp_2",         1, 32'h44, 0, 32'h00, 0, 32'h0,   1,   1, 1, 32'h300,13, 2);
        step("misp_3",         1, 32'h44, 0, 32'h00, 0, 32'h0,   0,   1, 1, 32'h300,13, 3);
        step("misp_hold",      1, 32'h44, 0, 32'h00, 0, 32'h0,   0,   1, 1, 32'h300,13, 3);

        // Preload both counters close to saturation between edges.
        @(negedge clk);
        #1;
        dut.r_ctrl_count = MX1;
        dut.r_misp_count = MX1;

        step("sat_preload",    1, 32'h44, 1, 32'h44, 1, 32'h300, 1,   1, 1, 32'h300, MX1, MX1);
        step("sat_reach",      1, 32'h44, 1, 32'h44, 1, 32'h300, 1,   1, 1, 32'h300, MX,  MX);
        step("sat_hold1",      1, 32'h44, 1, 32'h44, 1, 32'h300, 1,   1, 1, 32'h300, MX,  MX);
        step("sat_hold2",      1, 32'h44, 0, 32'h00, 0, 32'h0,   0,   1, 1, 32'h300, MX,  MX);
        step("rst_with_upd",   0, 32'h44, 1, 32'h48, 1, 32'h400, 1,   1, 1, 32'h300, MX,  MX);
        step("post_rst_44",    1, 32'h44, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,   0, 0);
        step("post_rst_80",    1, 32'h80, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,   0, 0);
        step("post_rst_48",    1, 32'h48, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,   0, 0);
        step("post_rst_40",    1, 32'h40, 0, 32'h00, 0, 32'h0,   0,   0, 0, 32'h0,   0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q_exp.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer and 2-bit direction predictor for the IF stage. It is the consumer of the EX-stage resolution interface: EX trains the table with resolved PC, outcome and target. The table in turn supplies predictedTaken and the predicted target to fetch; predictedTaken travels down the pipeline to EX. The block also keeps saturating performance counters for resolved control-flow instructions and mispredictions.

## Interface
- INDEX_BITS, 4, log2 of entry count (16 entries); tag width TAG_W = 30 - INDEX_BITS
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- pc_if  in  32  fetch PC being looked up
- predictedTaken_if  out  1  prediction for pc_if (hit AND counter[1])
- predicted_target_if  out  32  stored target on hit, else 0
- btb_hit_if  out  1  valid entry with matching tag for pc_if
- update_btb_ex  in  1  a branch/JAL/JALR resolved in EX this cycle
- pc_ex  in  32  PC of resolved instruction
- ex_branch_taken  in  1  actual outcome
- jump_addr_ex  in  32  computed target
- modify_pc_ex  in  1  EX mispredict/redirect flag
- ctrl_count  out  32  resolved control-flow instructions, saturating
- mispredict_count  out  32  mispredictions, saturating

## Operation
- Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
- Entry fields: valid (1), tag (TAG_W), target (32), ctr (2-bit saturating).
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup is combinational from the registered table:
  - btb_hit_if = valid[idx] & (tag[idx] == tag(pc_if)).
  - predictedTaken_if = btb_hit_if & ctr[idx][1].
  - predicted_target_if = btb_hit_if ? target[idx] : 0.
- Update happens on a clk edge with update_btb_ex=1. Index and tag come from pc_ex.
- Hit, taken:
  - ctr = min(ctr+1, 3).
  - target = jump_addr_ex, so a changed JALR target replaces the old one.
- Hit, not taken: ctr = max(ctr-1, 0). Target is unchanged.
- Miss, taken:
  - Allocate the entry, overwriting any alias.
  - valid=1, tag=tag(pc_ex), target=jump_addr_ex, ctr=10.
- Miss, not taken: no table change. Not-taken branches are never allocated.
- update_btb_ex=0: the table holds its state. modify_pc_ex still counts.
- ctrl_count increments by 1 on each cycle with update_btb_ex=1.
- mispredict_count increments by 1 on each cycle with modify_pc_ex=1.
- Both counters stop at 0xFFFF_FFFF and do not wrap.

## Timing
- Lookup latency: 0 cycles (same-cycle combinational from pc_if).
- Update latency: an update is visible to lookups in the cycle after the update edge.
- Same index in lookup and update in one cycle: the lookup returns pre-update contents (read-before-write). There is no bypass.
- Reset (rst_n=0 at a rising edge) applies in one cycle:
  - All valid=0, tag=0, target=0, ctr=01.
  - ctrl_count=0, mispredict_count=0.
  - Outputs are therefore 0 from the first cycle after reset.
- Reset asserted during an update cycle: reset wins and the update is discarded.
- Update inputs are sampled only at the edge. There is no handshake; EX asserts update_btb_ex for exactly one cycle per resolved instruction.
- Outputs are undefined-free: no X is allowed after reset, even for unlooked indices.

## Test plan
- Reset, then lookup pc_if=0x0000_0040:
  - Required: btb_hit_if=0, predictedTaken_if=0, predicted_target_if=0, both counters 0.
- Taken allocate: update pc_ex=0x40, taken=1, target=0x100.
  - Next cycle, lookup 0x40: hit=1, predictedTaken_if=1, target=0x100, ctrl_count=1.
- Counter saturation on pc 0x40:
  - Two more taken updates: ctr=11.
  - Then three not-taken updates: ctr 10, 01, 00; predictedTaken_if=0 after the second.
  - A fourth not-taken update keeps ctr=00.
- Aliasing: update pc_ex=0x80 (same index 0, tag 2), taken, target=0x200.
  - Lookup 0x40: hit=0.
  - Lookup 0x80: hit=1, target=0x200.
  - A not-taken update at 0x0C0 allocates nothing.
- Same-cycle conflict:
  - pc_if=0x80 together with a not-taken update at 0x80 while ctr=10.
  - Same cycle: predictedTaken_if=1. Next cycle: predictedTaken_if=0.
- Counters and reset:
  - Assert modify_pc_ex for 3 cycles: mispredict_count=3.
  - Preload counts to 0xFFFF_FFFE and apply 2 more events: both hold 0xFFFF_FFFF.
  - rst_n=0 for one edge: counters and all table entries clear.
